// File: rtl/aes_mem_pkg.sv
// Shared definitions for the sequenced data memory.
//   BANK_W       : width of one RAM word / one beat of a vector access
//   state_e      : access FSM encoding
//   addr_aligned : alignment check for scalar and vector requests
package aes_mem_pkg;

    localparam int unsigned BANK_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Scalar accesses need word alignment; vector accesses need VLEN/8-byte alignment.
    function automatic logic addr_aligned(input logic [31:0] addr,
                                          input logic        vector,
                                          input int unsigned vlen);
        logic [31:0] mask;
        mask = vector ? 32'(vlen / 8 - 1) : 32'd3;
        return (addr & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/vdatamem_seq_if.sv
// Load/store bus between the core and vdatamem_seq.
//   master : drives req/we/vector/addr/wmem/wdata, sees ready/done/rdata/err
//   slave  : the memory side
interface vdatamem_seq_if #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned AW   = 12
);
    logic            req;
    logic            we;
    logic            vector;
    logic [AW-1:0]   addr;
    logic [3:0]      wmem;
    logic [VLEN-1:0] wdata;
    logic            ready;
    logic            done;
    logic [VLEN-1:0] rdata;
    logic            err;

    modport master (
        output req, we, vector, addr, wmem, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, vector, addr, wmem, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/spram32_be.sv
// DEPTH x 32 single-port synchronous RAM with per-byte write enables.
//   clk     : clock
//   en_i    : access enable (read when we_i = 0)
//   we_i    : write enable
//   be_i    : byte enables for writes
//   addr_i  : word address
//   wdata_i : write word
//   rdata_o : read word, registered one edge after the address
module spram32_be
    import aes_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [BANK_W-1:0]        wdata_i,
    output logic [BANK_W-1:0]        rdata_o
);

    logic [BANK_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/vdatamem_seq.sv
// Sequenced data memory: one 32-bit byte-writable RAM serving scalar and
// VLEN-bit vector accesses, a vector access streamed over VLEN/32 beats.
//   clk  : clock
//   clrn : asynchronous active-low reset
//   bus  : load/store bus (slave side): req/we/vector/addr/wmem/wdata in,
//          ready/done/rdata/err out
module vdatamem_seq
    import aes_mem_pkg::*;
#(
    parameter int unsigned VLEN  = 128,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 12
) (
    input  logic           clk,
    input  logic           clrn,
    vdatamem_seq_if.slave  bus
);

    localparam int unsigned NB  = VLEN / BANK_W;
    localparam int unsigned WAW = AW - 2;
    localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;

    state_e                    state_q;
    logic [BW-1:0]             beat_q;
    logic                      we_q;
    logic                      vec_q;
    logic [WAW-1:0]            base_q;
    logic [3:0]                wmem_q;
    logic [NB-1:0][BANK_W-1:0] wdata_q;
    logic                      ready_q;
    logic                      done_q;
    logic                      err_q;
    logic                      reject_q;
    logic [NB-1:0][BANK_W-1:0] rdata_q;
    logic [NB-1:0][BANK_W-1:0] rdata_d;
    logic [NB-1:0][BANK_W-1:0] rbuf_q;
    logic [NB-1:0][BANK_W-1:0] rbuf_d;

    // Read-return pipeline: tracks the beat whose RAM data arrives this cycle.
    logic                      rd_pend_q;
    logic                      rd_last_q;
    logic                      rd_vec_q;
    logic [BW-1:0]             rd_beat_q;

    logic                      accept_c;
    logic                      aligned_c;
    logic                      last_beat_c;
    logic                      ram_en_d;
    logic [WAW-1:0]            ram_addr_d;
    logic [3:0]                ram_be_d;
    logic [BANK_W-1:0]         ram_wdata_d;
    logic [BANK_W-1:0]         ram_rdata;

    assign accept_c    = bus.req & ready_q;
    assign aligned_c   = addr_aligned(32'(bus.addr), bus.vector, VLEN);
    assign last_beat_c = vec_q ? (beat_q == BW'(NB - 1)) : 1'b1;

    // RAM port driven straight from the captured operands and the beat counter.
    always_comb begin
        ram_en_d    = (state_q == BUSY);
        ram_addr_d  = base_q + WAW'(beat_q);
        ram_be_d    = vec_q ? 4'hF : wmem_q;
        ram_wdata_d = wdata_q[beat_q];
    end

    // Vector slices collect in rbuf so rdata only changes when a read completes.
    always_comb begin
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        if (rd_pend_q) begin
            rbuf_d[rd_beat_q] = ram_rdata;
            if (rd_last_q) begin
                if (rd_vec_q) begin
                    rdata_d = rbuf_d;
                end else begin
                    rdata_d    = '0;
                    rdata_d[0] = ram_rdata;
                end
            end
        end
    end

    // Access FSM, beat counter, operand capture and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            we_q      <= 1'b0;
            vec_q     <= 1'b0;
            base_q    <= '0;
            wmem_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            reject_q  <= 1'b0;
            rdata_q   <= '0;
            rbuf_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
            rd_vec_q  <= 1'b0;
            rd_beat_q <= '0;
        end else begin
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
            err_q     <= reject_q;
            rdata_q   <= rdata_d;
            rbuf_q    <= rbuf_d;
            rd_pend_q <= (state_q == BUSY) && !we_q;
            rd_last_q <= (state_q == BUSY) && last_beat_c;
            rd_vec_q  <= vec_q;
            rd_beat_q <= beat_q;

            case (state_q)
                BUSY: begin
                    if (last_beat_c) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        beat_q  <= '0;
                    end else begin
                        beat_q  <= beat_q + BW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE also reports completion.
                    done_q  <= (state_q == DONE);
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        if (aligned_c) begin
                            state_q <= BUSY;
                            ready_q <= 1'b0;
                            beat_q  <= '0;
                            we_q    <= bus.we;
                            vec_q   <= bus.vector;
                            base_q  <= bus.addr[AW-1:2];
                            wmem_q  <= bus.wmem;
                            wdata_q <= bus.wdata;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    spram32_be #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_d),
        .we_i    (we_q),
        .be_i    (ram_be_d),
        .addr_i  (ram_addr_d),
        .wdata_i (ram_wdata_d),
        .rdata_o (ram_rdata)
    );

endmodule
